// File: rtl/ntsc_pkg.sv
// Shared constants, pulse classes and flywheel states for the NTSC sync separator.
package ntsc_pkg;

  localparam int unsigned C_H_TOTAL   = 910;
  localparam int unsigned C_HS_MIN    = 50;
  localparam int unsigned C_HS_MAX    = 90;
  localparam int unsigned C_EQ_MIN    = 20;
  localparam int unsigned C_EQ_MAX    = 45;
  localparam int unsigned C_BROAD_MIN = 300;

  typedef enum logic [2:0] {NONE, HS, EQ, BROAD, NOISE} pulse_cls_t;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} fsm_state_t;

  function automatic pulse_cls_t classify(input logic [9:0] pw);
    if (pw >= 10'(C_HS_MIN) && pw <= 10'(C_HS_MAX)) return HS;
    if (pw >= 10'(C_EQ_MIN) && pw <= 10'(C_EQ_MAX)) return EQ;
    if (pw >= 10'(C_BROAD_MIN)) return BROAD;
    return NOISE;
  endfunction

endpackage

// File: rtl/ntsc_sync_pulse_meas.sv
// Sync slicer, pulse width counter, falling-edge capture and pulse classifier.
// NTSC_SYNC_SEP_MAJ_FILT_EN adds a 3-tap majority filter ahead of the slice register.
module ntsc_sync_pulse_meas
  import ntsc_pkg::*;
#(
  parameter int unsigned C_DAT_W    = 9,
  parameter int unsigned C_SLICE_LV = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ee,
  input  logic [C_DAT_W-1:0] video,
  input  logic [9:0]         hctr,
  output logic               sync,
  output pulse_cls_t         cls,
  output logic [9:0]         pw,
  output logic [9:0]         fe_h
);

  logic slice;
  logic s_next;
  logic s;
  logic s_d;

  assign slice = (video < C_DAT_W'(C_SLICE_LV));

`ifdef NTSC_SYNC_SEP_MAJ_FILT_EN
  logic [2:0] raw;

  always_ff @(posedge clk) begin
    if (rst)     raw <= '0;
    else if (ee) raw <= {raw[1:0], slice};
  end

  assign s_next = (raw[0] & raw[1]) | (raw[0] & raw[2]) | (raw[1] & raw[2]);
`else
  assign s_next = slice;
`endif

  // Edges are taken on the registered decision so PW and FE_H both see the filtered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= 1'b0;
      s_d  <= 1'b0;
      pw   <= '0;
      fe_h <= '0;
    end else if (ee) begin
      s   <= s_next;
      s_d <= s;
      if (s && !s_d) fe_h <= hctr;
      if (!s && s_d)                pw <= '0;
      else if (s && (pw != 10'h3FF)) pw <= pw + 10'd1;
    end
  end

  assign cls  = (!s && s_d) ? classify(pw) : NONE;
  assign sync = s;

endmodule

// File: rtl/ntsc_sync_sep.sv
// NTSC composite sync separator: H flywheel lock, vertical counter and field recovery.
// Optional majority filter on the slicer via NTSC_SYNC_SEP_MAJ_FILT_EN.
module ntsc_sync_sep
  import ntsc_pkg::*;
#(
  parameter int unsigned C_DAT_W    = 9,
  parameter int unsigned C_SLICE_LV = 64,
  parameter int unsigned C_LOCK_CNT = 8,
  parameter int unsigned C_MISS_MAX = 4
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               CK_EE_i,
  input  logic [C_DAT_W-1:0] VIDEOs_i,
  output logic               SYNC_o,
  output logic               XHD_o,
  output logic               XVD_o,
  output logic [9:0]         HCTRs_o,
  output logic [9:0]         VCTRs_o,
  output logic               FIELD_o,
  output logic               LOCK_o,
  output logic               V_VALID_o
);

  localparam logic [9:0] H_LAST   = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] H_WIN_LO = 10'(C_H_TOTAL - 2);
  localparam logic [9:0] H_Q1     = 10'(C_H_TOTAL / 4);
  localparam logic [9:0] H_Q3     = 10'(3 * C_H_TOTAL / 4);

  pulse_cls_t cls;
  logic [9:0] pw;
  logic [9:0] fe_h;

  fsm_state_t state, state_n;
  logic [9:0] hctr, hctr_n, vctr, vctr_n;
  logic [7:0] good, good_n, miss, miss_n;
  logic       seen, seen_n, arm, arm_n, vpend, vpend_n;
  logic       field_n, lock_n, vvalid_n;
  logic       wrap, in_win, is_hs, rephase, seen_now, v_ev;

  ntsc_sync_pulse_meas #(
    .C_DAT_W   (C_DAT_W),
    .C_SLICE_LV(C_SLICE_LV)
  ) u_meas (
    .clk  (CK_i),
    .rst  (RST_i),
    .ee   (CK_EE_i),
    .video(VIDEOs_i),
    .hctr (hctr),
    .sync (SYNC_o),
    .cls  (cls),
    .pw   (pw),
    .fe_h (fe_h)
  );

  assign wrap     = (hctr == H_LAST);
  assign in_win   = (fe_h >= H_WIN_LO) || (fe_h <= 10'd2);
  assign is_hs    = (cls == HS);
  assign rephase  = is_hs && ((state == SEARCH) || (state == VERIFY && !in_win));
  assign seen_now = seen || (cls == EQ) || (cls == BROAD) || (is_hs && in_win);
  assign v_ev     = (cls == BROAD) && arm && !vpend;

  always_comb begin
    state_n  = state;
    good_n   = good;
    miss_n   = miss;
    seen_n   = seen;
    arm_n    = arm;
    vpend_n  = vpend;
    field_n  = FIELD_o;
    lock_n   = LOCK_o;
    vvalid_n = V_VALID_o;
    hctr_n   = wrap ? '0 : hctr + 10'd1;
    vctr_n   = vctr;

    // Rephase puts the last falling edge at HCTR=0; it replaces the wrap but not the V update.
    if (rephase) hctr_n = pw + 10'd1;

    if (vctr >= 10'd200) arm_n = 1'b1;
    if (vctr == 10'd600) vvalid_n = 1'b0;
    if (v_ev) begin
      field_n = (fe_h < H_Q1 || fe_h >= H_Q3) ? 1'b0 : 1'b1;
      vpend_n = 1'b1;
      if (LOCK_o) vvalid_n = 1'b1;
    end
    if (wrap) begin
      if (vpend) begin
        vctr_n  = '0;
        vpend_n = 1'b0;
        arm_n   = 1'b0;
      end else if (vctr != '1) begin
        vctr_n = vctr + 10'd1;
      end
    end

    case (state)
      SEARCH: begin
        seen_n = 1'b0;
        if (is_hs) begin
          state_n = VERIFY;
          good_n  = '0;
        end
      end
      VERIFY: begin
        seen_n = 1'b0;
        if (is_hs) begin
          if (!in_win) begin
            good_n = '0;
          end else if (good == 8'(C_LOCK_CNT - 1)) begin
            state_n = LOCK;
            lock_n  = 1'b1;
            miss_n  = '0;
          end else begin
            good_n = good + 8'd1;
          end
        end
      end
      LOCK: begin
        if (wrap) begin
          seen_n = 1'b0;
          if (seen_now) begin
            miss_n = '0;
          end else if (miss == 8'(C_MISS_MAX - 1)) begin
            state_n  = SEARCH;
            lock_n   = 1'b0;
            vvalid_n = 1'b0;
            miss_n   = '0;
          end else begin
            miss_n = miss + 8'd1;
          end
        end else begin
          seen_n = seen_now;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state     <= SEARCH;
      hctr      <= '0;
      vctr      <= '1;
      good      <= '0;
      miss      <= '0;
      seen      <= 1'b0;
      arm       <= 1'b1;
      vpend     <= 1'b0;
      FIELD_o   <= 1'b0;
      LOCK_o    <= 1'b0;
      V_VALID_o <= 1'b0;
      XHD_o     <= 1'b1;
      XVD_o     <= 1'b1;
    end else if (CK_EE_i) begin
      state     <= state_n;
      hctr      <= hctr_n;
      vctr      <= vctr_n;
      good      <= good_n;
      miss      <= miss_n;
      seen      <= seen_n;
      arm       <= arm_n;
      vpend     <= vpend_n;
      FIELD_o   <= field_n;
      LOCK_o    <= lock_n;
      V_VALID_o <= vvalid_n;
      XHD_o     <= (hctr_n != H_LAST);
      XVD_o     <= (vctr_n != 10'd0);
    end
  end

  assign HCTRs_o = hctr;
  assign VCTRs_o = vctr;

endmodule

// File: tb/tb_ntsc_sync_sep.sv
// Scoreboard bench for ntsc_sync_sep: random-level synthetic NTSC lines versus a tick model.
`timescale 1ns/1ps
module tb_ntsc_sync_sep;

  logic       clk = 1'b0;
  logic       rst, ee;
  logic [8:0] video;
  logic       sync_o, xhd_o, xvd_o, field_o, lock_o, vvalid_o;
  logic [9:0] hctr_o, vctr_o;

  always #5 clk = ~clk;

  ntsc_sync_sep dut (
    .CK_i     (clk),
    .RST_i    (rst),
    .CK_EE_i  (ee),
    .VIDEOs_i (video),
    .SYNC_o   (sync_o),
    .XHD_o    (xhd_o),
    .XVD_o    (xvd_o),
    .HCTRs_o  (hctr_o),
    .VCTRs_o  (vctr_o),
    .FIELD_o  (field_o),
    .LOCK_o   (lock_o),
    .V_VALID_o(vvalid_o)
  );

  typedef struct {
    int sync, xhd, xvd, hctr, vctr, field, lock, vvalid;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad   = 0;

  // Reference model, one call per enabled tick. mode: 0 search, 1 verify, 2 locked.
  int m_s, m_prev, m_pw, m_feh, m_h, m_v, m_mode, m_good, m_miss;
  int m_seen, m_arm, m_vpend, m_field, m_lock, m_vvalid;
  int hist[3];

  task automatic m_reset();
    m_s = 0; m_prev = 0; m_pw = 0; m_feh = 0; m_h = 0; m_v = 1023;
    m_mode = 0; m_good = 0; m_miss = 0; m_seen = 0; m_arm = 1; m_vpend = 0;
    m_field = 0; m_lock = 0; m_vvalid = 0;
    hist[0] = 0; hist[1] = 0; hist[2] = 0;
  endtask

  task automatic m_tick(input int vid);
    int slice, s_new, kind, h_n, v_n, mode_n, good_n, miss_n;
    int seen_n, arm_n, vpend_n, field_n, lock_n, vvalid_n;
    int fe, re, wrap, inwin, seen_now, vev;
    slice = (vid < 64) ? 1 : 0;
`ifdef NTSC_SYNC_SEP_MAJ_FILT_EN
    s_new = ((hist[0] + hist[1] + hist[2]) >= 2) ? 1 : 0;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = slice;
`else
    s_new = slice;
`endif
    fe = (m_s == 1 && m_prev == 0);
    re = (m_s == 0 && m_prev == 1);
    kind = 0;
    if (re) begin
      if (m_pw >= 50 && m_pw <= 90)      kind = 1;
      else if (m_pw >= 20 && m_pw <= 45) kind = 2;
      else if (m_pw >= 300)              kind = 3;
      else                               kind = 4;
    end
    wrap     = (m_h == 909);
    inwin    = (m_feh >= 908 || m_feh <= 2);
    seen_now = m_seen || kind == 2 || kind == 3 || (kind == 1 && inwin);
    vev      = (kind == 3 && m_arm == 1 && m_vpend == 0);

    h_n = (m_h + 1) % 910; v_n = m_v; mode_n = m_mode; good_n = m_good; miss_n = m_miss;
    seen_n = m_seen; arm_n = m_arm; vpend_n = m_vpend; field_n = m_field;
    lock_n = m_lock; vvalid_n = m_vvalid;

    if (m_v >= 200) arm_n = 1;
    if (m_v == 600) vvalid_n = 0;
    if (vev) begin
      field_n = (m_feh < 227 || m_feh >= 682) ? 0 : 1;
      vpend_n = 1;
      if (m_lock) vvalid_n = 1;
    end
    if (wrap) begin
      if (m_vpend) begin v_n = 0; vpend_n = 0; arm_n = 0; end
      else v_n = (m_v < 1023) ? m_v + 1 : 1023;
    end

    if (m_mode == 0) begin
      seen_n = 0;
      if (kind == 1) begin h_n = m_pw + 1; mode_n = 1; good_n = 0; end
    end else if (m_mode == 1) begin
      seen_n = 0;
      if (kind == 1) begin
        if (inwin) begin
          good_n = m_good + 1;
          if (good_n == 8) begin mode_n = 2; lock_n = 1; miss_n = 0; end
        end else begin
          h_n = m_pw + 1; good_n = 0;
        end
      end
    end else if (wrap) begin
      seen_n = 0;
      if (seen_now) miss_n = 0;
      else begin
        miss_n = m_miss + 1;
        if (miss_n == 4) begin mode_n = 0; lock_n = 0; vvalid_n = 0; miss_n = 0; end
      end
    end else begin
      seen_n = seen_now;
    end

    if (re)        m_pw = 0;
    else if (m_s)  m_pw = (m_pw < 1023) ? m_pw + 1 : 1023;
    if (fe) m_feh = m_h;
    m_prev = m_s; m_s = s_new;
    m_h = h_n; m_v = v_n; m_mode = mode_n; m_good = good_n; m_miss = miss_n;
    m_seen = seen_n; m_arm = arm_n; m_vpend = vpend_n; m_field = field_n;
    m_lock = lock_n; m_vvalid = vvalid_n;
  endtask

  task automatic push_exp();
    exp_t e;
    e.sync = m_s; e.xhd = (m_h != 909); e.xvd = (m_v != 0);
    e.hctr = m_h; e.vctr = m_v; e.field = m_field; e.lock = m_lock; e.vvalid = m_vvalid;
    expq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every edge that consumes stimulus (enable or reset) pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst === 1'b1 || ee === 1'b1) begin
        #1;
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard: got empty queue, expected an entry (t=%0t)", $time);
        end else begin
          e = expq.pop_front();
          chk("sync",    32'(sync_o),   32'(e.sync));
          chk("xhd",     32'(xhd_o),    32'(e.xhd));
          chk("xvd",     32'(xvd_o),    32'(e.xvd));
          chk("hctr",    32'(hctr_o),   32'(e.hctr));
          chk("vctr",    32'(vctr_o),   32'(e.vctr));
          chk("field",   32'(field_o),  32'(e.field));
          chk("lock",    32'(lock_o),   32'(e.lock));
          chk("vvalid",  32'(vvalid_o), 32'(e.vvalid));
        end
      end
    end
  end

  task automatic step(input int r, input int en, input int vid);
    rst = (r != 0); ee = (en != 0); video = 9'(vid);
    if (r != 0) begin m_reset(); push_exp(); end
    else if (en != 0) begin m_tick(vid); push_exp(); end
    @(negedge clk);
  endtask

  task automatic tick(input int vid);
    if ($urandom_range(0, 31) == 0) step(0, 0, int'($urandom_range(0, 511)));
    step(0, 1, vid);
  endtask

  // One line of len ticks; up to two low pulses; optional 1-tick glitches during active video.
  task automatic line(input int len, input int a_s, input int a_w,
                      input int b_s, input int b_w, input int glitch);
    int low, g, vid;
    for (int t = 0; t < len; t++) begin
      low = (t >= a_s && t < a_s + a_w) || (t >= b_s && t < b_s + b_w);
      g   = (glitch != 0) && t >= 150 && t <= 850 && (t % 100) == 50;
      if (g)        vid = 0;
      else if (low) vid = int'($urandom_range(0, 63));
      else          vid = int'($urandom_range(64, 511));
      tick(vid);
    end
  endtask

  task automatic hs_lines(input int n);
    for (int i = 0; i < n; i++) line(910, 0, 67, 0, 0, 0);
  endtask

  initial begin
    int idle;
    rst = 1'b1; ee = 1'b0; video = '0;
    step(1, 0, 0);
    step(1, 1, 0);
    chk("reset_vctr", 32'(vctr_o), 32'd1023);
    chk("reset_xhd",  32'(xhd_o),  32'd1);
    chk("reset_lock", 32'(lock_o), 32'd0);
    idle = int'($urandom_range(50, 400));
    for (int i = 0; i < idle; i++) tick(int'($urandom_range(64, 511)));

    // Acquire: SEARCH on 1st HS, 8 more in-window HS to lock.
    hs_lines(8);
    chk("lock_after_8_hs", 32'(lock_o), 32'd0);
    hs_lines(1);
    chk("lock_after_9_hs", 32'(lock_o), 32'd1);
    hs_lines(1);

    // Flywheel: 3 missed lines hold lock, 4 drop it at the following wrap.
    for (int i = 0; i < 3; i++) line(910, 0, 0, 0, 0, 0);
    hs_lines(2);
    chk("lock_3_missed", 32'(lock_o), 32'd1);
    for (int i = 0; i < 4; i++) line(910, 0, 0, 0, 0, 0);
    chk("lock_before_4th_wrap", 32'(lock_o), 32'd1);
    line(910, 0, 0, 0, 0, 0);
    chk("lock_4_missed", 32'(lock_o), 32'd0);

    // VERIFY with one HS late by 20 ticks: good restarts, 8 more needed.
    hs_lines(2);
    line(930, 0, 67, 0, 0, 0);
    line(910, 0, 67, 0, 0, 0);
    chk("shift_hctr_realigned", 32'(hctr_o), 32'd909);
    hs_lines(7);
    chk("lock_7_after_shift", 32'(lock_o), 32'd0);
    hs_lines(1);
    chk("lock_8_after_shift", 32'(lock_o), 32'd1);
    hs_lines(3);

    // Vertical interval with the first broad edge at HCTR=0.
    for (int i = 0; i < 3; i++) line(910, 0, 33, 455, 33, 0);
    for (int i = 0; i < 3; i++) line(910, 0, 388, 455, 388, 0);
    for (int i = 0; i < 3; i++) line(910, 0, 33, 455, 33, 0);
    hs_lines(2);
    chk("field_odd",   32'(field_o),  32'd0);
    chk("vvalid_lock", 32'(vvalid_o), 32'd1);
    chk("vctr_after",  32'(vctr_o),   32'd6);
    chk("lock_vi",     32'(lock_o),   32'd1);

    // Glitches during active video while locked.
    for (int i = 0; i < 3; i++) line(910, 0, int'($urandom_range(55, 85)), 0, 0, 1);
    chk("lock_glitch", 32'(lock_o), 32'd1);

    // One-clock reset with the tick enable low.
    for (int i = 0; i < 300; i++) tick(int'($urandom_range(64, 511)));
    step(1, 0, int'($urandom_range(0, 511)));
    chk("rst_vctr",   32'(vctr_o),   32'd1023);
    chk("rst_xvd",    32'(xvd_o),    32'd1);
    chk("rst_hctr",   32'(hctr_o),   32'd0);
    chk("rst_lock",   32'(lock_o),   32'd0);
    chk("rst_vvalid", 32'(vvalid_o), 32'd0);
    chk("rst_sync",   32'(sync_o),   32'd0);

    // Interval with the first broad edge at HCTR=455, unlocked.
    idle = int'($urandom_range(20, 200));
    for (int i = 0; i < idle; i++) tick(int'($urandom_range(64, 511)));
    hs_lines(2);
    for (int i = 0; i < 2; i++) line(910, 0, 33, 455, 33, 0);
    line(910, 0, 33, 455, 388, 0);
    for (int i = 0; i < 2; i++) line(910, 0, 388, 455, 388, 0);
    line(910, 0, 388, 455, 33, 0);
    for (int i = 0; i < 3; i++) line(910, 0, 33, 455, 33, 0);
    hs_lines(1);
    chk("field_even",     32'(field_o),  32'd1);
    chk("vvalid_no_lock", 32'(vvalid_o), 32'd0);

    step(0, 0, 0);
    step(0, 0, 0);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntsc_sync_sep.md
Name: ntsc_sync_sep

Overview:
- Receive-side counterpart of the composite NTSC generator: takes digitised composite video samples at 4fsc and recovers H/V timing.
- Slices sync and measures pulse widths, classifying each pulse as HSYNC, equalising or broad (vertical serration).
- A flywheel state machine locks the horizontal counter; vertical counter and field are derived from the broad pulses.
- Outputs XHD/XVD/HCTR/VCTR use the same conventions as the transmit timing generator, so the CHR_GEN overlay can run on external video.

Parameters:
- C_DAT_W, 9, composite sample width.
- C_SLICE_LV, 64, sync slice level; a sample is sync when it is below this value.
- C_H_TOTAL, 910, 4fsc ticks per line.
- C_HS_MIN / C_HS_MAX, 50 / 90, HSYNC width window in ticks (inclusive).
- C_EQ_MIN / C_EQ_MAX, 20 / 45, equalising pulse width window (inclusive).
- C_BROAD_MIN, 300, minimum broad pulse width.
- C_LOCK_CNT, 8, consecutive in-window HSYNCs needed to reach LOCK.
- C_MISS_MAX, 4, consecutive missed lines that drop LOCK.

Ports:
- CK_i  in  1  system clock (NFSC clock).
- RST_i  in  1  synchronous reset, active high.
- CK_EE_i  in  1  4fsc tick enable; all state advances only when CK_EE_i=1.
- VIDEOs_i  in  C_DAT_W  composite samples, unsigned.
- SYNC_o  out  1  registered sliced sync, 1 = sync tip.
- XHD_o  out  1  0 for one tick when HCTR==C_H_TOTAL-1.
- XVD_o  out  1  0 for the whole line while VCTR==0.
- HCTRs_o  out  10  horizontal counter.
- VCTRs_o  out  10  vertical counter.
- FIELD_o  out  1  0 = odd field, 1 = even field.
- LOCK_o  out  1  H lock achieved.
- V_VALID_o  out  1  vertical phase is valid.

Behaviour:
- Reset values: SYNC_o=0, XHD_o=1, XVD_o=1, HCTR=0, VCTR=1023, FIELD_o=0, LOCK_o=0, V_VALID_o=0, FSM=SEARCH, PW=0.
- Slicer: S <= (VIDEOs_i < C_SLICE_LV); SYNC_o=S (1 tick latency).
- Falling edge = first tick with S=1 after S=0. Capture FE_H = HCTR at that tick.
- PW counts ticks while S=1 and saturates at 1023.
- Rising edge (S 1→0) classifies the pulse:
  - HS if PW is in the HS window.
  - EQ if PW is in the EQ window.
  - BROAD if PW ≥ C_BROAD_MIN.
  - otherwise NOISE, which is ignored.
- Classification fires on the first tick after the pulse, then PW clears.
- HCTR: increments every tick and wraps C_H_TOTAL-1→0, except when rephased.
- H window: FE_H ∈ {C_H_TOTAL-2, C_H_TOTAL-1, 0, 1, 2}.
- FSM SEARCH: on HS, HCTR <= PW+1 so the falling edge aligns to 0; goto VERIFY with good=0.
- FSM VERIFY:
  - HS in window: good++. When good reaches C_LOCK_CNT: goto LOCK, LOCK_o=1, miss=0.
  - HS outside window: rephase as in SEARCH, good=0, stay in VERIFY.
- FSM LOCK: no rephasing (flywheel).
  - HS in window sets the line "seen" flag.
  - EQ or BROAD anywhere in the line also sets "seen".
  - At HCTR wrap: if "seen", miss=0; else miss++. Clear "seen".
  - When miss reaches C_MISS_MAX: goto SEARCH, LOCK_o=0, V_VALID_o=0.
  - HS outside the window in LOCK is ignored.
- VCTR: increments at HCTR wrap and saturates at 1023.
- V event: the first BROAD after arm. Arm is set at reset and when VCTR ≥ 200.
  - FIELD_o <= 0 if FE_H < C_H_TOTAL/4 or FE_H ≥ 3*C_H_TOTAL/4; else FIELD_o <= 1.
  - Pending-V is set; at the next HCTR wrap VCTR <= 0 and arm is cleared.
  - V_VALID_o <= 1 only if LOCK_o=1.
- V_VALID_o clears when VCTR reaches 600.
- XHD_o and XVD_o are registered from the HCTR/VCTR values of the same tick.
- Simultaneous events:
  - Rephase in SEARCH/VERIFY overrides the wrap increment.
  - If a V-pending wrap coincides with a rephase, VCTR still loads 0.
- Reset mid-operation returns every output to its reset value on the next clock, independent of CK_EE_i.

Optional Feature:
- Macro NTSC_SYNC_SEP_MAJ_FILT_EN.
- Defined: S is a 3-tap majority of the raw slice decisions over the last 3 ticks. Adds 2 ticks of latency to SYNC_o and all edges. Single-tick glitches are rejected. HCTR alignment is unchanged because PW measures the filtered pulse.
- Undefined: direct slice with 1-tick latency.

Decomposition:
- Package ntsc_pkg: C_H_TOTAL, the pulse width windows, and the pulse class enum (NONE, HS, EQ, BROAD, NOISE) and FSM state enum (SEARCH, VERIFY, LOCK).
- Sub-module ntsc_sync_pulse_meas: slicer, optional filter, PW counter, FE capture and classifier. Outputs are a 1-tick class strobe plus PW and FE_H.
- The FSM and counters stay in the top module.

Test Plan:
- Ideal lines, HS width 67, 910-tick period, 10 lines → LOCK_o rises 1 tick after the 9th HS classification. HCTRs_o=0 at each falling edge. XHD_o low at HCTR=909.
- Locked, then sync removed for 4 lines → LOCK_o=0 at the 4th missed wrap. Removed for 3 lines → LOCK stays 1.
- Full NTSC vertical interval (6 EQ width 33, 6 BROAD width 388, 6 EQ), first broad falling edge at HCTR=0 → FIELD_o=0, VCTR=0 on the next line, XVD_o low for 910 ticks. First broad edge at HCTR=455 → FIELD_o=1.
- 1-tick glitches (VIDEOs_i=0) every 100 ticks during active video in LOCK → LOCK holds, HCTR not rephased. With NTSC_SYNC_SEP_MAJ_FILT_EN, SYNC_o never shows the glitch.
- VERIFY with one HS shifted by +20 ticks → good resets to 0 and HCTR is rephased to the new edge. LOCK requires 8 more in-window HS.
- RST_i asserted mid-field for 1 clock with CK_EE_i=0 → all outputs take their reset values (VCTR=1023, XVD_o=1) on the next clock.
